// File: rtl/seg_text_scroller.sv
// ---------------------------------------------------------------------------
// seg_text_scroller
//
// Multiplexed 7-segment text engine. A small writable buffer holds active-low
// segment patterns; the engine scans the digits and shows the message either
// statically or as a circular scroll that advances every SCROLL_TICKS cycles.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   wr_en        buffer write strobe
//   wr_addr      buffer write address (addresses >= MSG_DEPTH are ignored)
//   wr_data      active-low segment pattern {dp,g,f,e,d,c,b,a}
//   msg_len      active message length, 0..MSG_DEPTH (larger values clamp)
//   mode         0 = static, 1 = circular scroll
//   anodo        active-low digit enables, one-hot-low (registered)
//   catodo       active-low segments for the selected digit (registered)
//   scroll_wrap  one-cycle pulse when the scroll position wraps to 0
//
// Build option:
//   SEG_DEADTIME_EN  when defined, the first 2^(SCAN_DIV_BITS-3) cycles of
//                    every digit slot are blanked to suppress ghosting.
// ---------------------------------------------------------------------------
module seg_text_scroller #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int MSG_DEPTH     = 16,
  parameter int SCROLL_TICKS  = 25000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
  input  logic [7:0]                     wr_data,
  input  logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
  input  logic                           mode,
  output logic [NUM_DIGITS-1:0]          anodo,
  output logic [7:0]                     catodo,
  output logic                           scroll_wrap
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  // Wide enough for position + digit index without overflow.
  localparam int CW = ((LW > DW) ? LW : DW) + 1;

  logic [SCAN_DIV_BITS-1:0] scan_q, scan_d;
  logic [DW-1:0]            dig_q, dig_d;
  logic [AW-1:0]            pos_q, pos_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic                     wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0]    anodo_q, anodo_d;
  logic [7:0]               catodo_q, catodo_d;
  logic [7:0]               buf_q [MSG_DEPTH];
  logic [7:0]               buf_d [MSG_DEPTH];

  logic [LW-1:0] len_eff;
  logic [CW-1:0] rd_idx;
  logic          rd_ok;
  logic          blank;

`ifdef SEG_DEADTIME_EN
  // Below 3 scan bits the blanking window rounds down to nothing.
  localparam int DEAD_SH = (SCAN_DIV_BITS >= 3) ? SCAN_DIV_BITS - 3 : 0;
  assign blank = (SCAN_DIV_BITS >= 3) &&
                 (scan_q < SCAN_DIV_BITS'(1 << DEAD_SH));
`else
  assign blank = 1'b0;
`endif

  assign len_eff = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;

  // Buffer writes; an out-of-range address matches no entry.
  always_comb begin
    for (int i = 0; i < MSG_DEPTH; i++) begin
      buf_d[i] = buf_q[i];
      if (wr_en && (wr_addr == AW'(i))) buf_d[i] = wr_data;
    end
  end

  // Digit scan.
  always_comb begin
    scan_d = scan_q + SCAN_DIV_BITS'(1);
    dig_d  = dig_q;
    if (scan_q == '1) begin
      dig_d = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
    end
  end

  // Scroll timer and position.
  always_comb begin
    tick_d = '0;
    pos_d  = '0;
    wrap_d = 1'b0;
    if (mode && (len_eff != '0)) begin
      tick_d = tick_q + TW'(1);
      pos_d  = pos_q;
      if (tick_q == TW'(SCROLL_TICKS - 1)) begin
        tick_d = '0;
        if (CW'(pos_q) == CW'(len_eff) - CW'(1)) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + AW'(1);
        end
      end
      // Message shrank underneath the position: restart silently.
      if (CW'(pos_q) >= CW'(len_eff)) begin
        pos_d  = '0;
        wrap_d = 1'b0;
      end
    end
  end

  // Output register input: pick the buffer entry for the current digit.
  always_comb begin
    rd_idx = '0;
    rd_ok  = 1'b0;
    if (mode) begin
      if (len_eff != '0) begin
        rd_ok  = 1'b1;
        rd_idx = (CW'(pos_q) + CW'(dig_q)) % CW'(len_eff);
      end
    end else if (CW'(dig_q) < CW'(len_eff)) begin
      rd_ok  = 1'b1;
      rd_idx = CW'(dig_q);
    end
    anodo_d  = ~(NUM_DIGITS'(1) << dig_q);
    catodo_d = rd_ok ? buf_q[AW'(rd_idx)] : 8'hFF;
    if (blank) begin
      anodo_d  = '1;
      catodo_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q   <= '0;
      dig_q    <= '0;
      pos_q    <= '0;
      tick_q   <= '0;
      wrap_q   <= 1'b0;
      anodo_q  <= '1;
      catodo_q <= 8'hFF;
      for (int i = 0; i < MSG_DEPTH; i++) buf_q[i] <= 8'hFF;
    end else begin
      scan_q   <= scan_d;
      dig_q    <= dig_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      anodo_q  <= anodo_d;
      catodo_q <= catodo_d;
      for (int i = 0; i < MSG_DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign anodo       = anodo_q;
  assign catodo      = catodo_q;
  assign scroll_wrap = wrap_q;

endmodule

// File: tb/tb_seg_text_scroller.sv
// ---------------------------------------------------------------------------
// tb_seg_text_scroller
//
// Directed bench for seg_text_scroller. Main instance: 8 digits, 2 scan bits
// (4-cycle slots), 16 entries, 10-cycle scroll step. A second instance with a
// 12-entry buffer covers out-of-range writes; with SEG_DEADTIME_EN defined a
// third instance with 4 scan bits covers the blanking window.
// k counts clock edges since the last reset release; samples are taken on
// the falling edge after edge k.
// ---------------------------------------------------------------------------
module tb_seg_text_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] msg_len;
  logic       mode;
  logic [7:0] anodo, catodo;
  logic       scroll_wrap;

  logic       wr_en2;
  logic [3:0] wr_addr2;
  logic [7:0] wr_data2;
  logic [3:0] msg_len2;
  logic [7:0] anodo2, catodo2;
  logic       scroll_wrap2;

  seg_text_scroller #(
    .NUM_DIGITS(8), .SCAN_DIV_BITS(2), .MSG_DEPTH(16), .SCROLL_TICKS(10)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .msg_len(msg_len), .mode(mode),
    .anodo(anodo), .catodo(catodo), .scroll_wrap(scroll_wrap)
  );

  seg_text_scroller #(
    .NUM_DIGITS(8), .SCAN_DIV_BITS(2), .MSG_DEPTH(12), .SCROLL_TICKS(10)
  ) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .msg_len(msg_len2), .mode(1'b0),
    .anodo(anodo2), .catodo(catodo2), .scroll_wrap(scroll_wrap2)
  );

`ifdef SEG_DEADTIME_EN
  logic [7:0] anodo3, catodo3;
  logic       scroll_wrap3;
  seg_text_scroller #(
    .NUM_DIGITS(8), .SCAN_DIV_BITS(4), .MSG_DEPTH(16), .SCROLL_TICKS(10)
  ) dut3 (
    .clk(clk), .reset(reset), .wr_en(1'b0), .wr_addr(4'd0),
    .wr_data(8'hFF), .msg_len(5'd0), .mode(1'b0),
    .anodo(anodo3), .catodo(catodo3), .scroll_wrap(scroll_wrap3)
  );
`endif

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [7:0] msg [4];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_en2  = 1'b0;
    wr_addr = '0;
    wr_addr2 = '0;
    wr_data = 8'hFF;
    wr_data2 = 8'hFF;
    msg_len = '0;
    msg_len2 = '0;
    mode    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    k = 0;
  endtask

  // Expected anodo after edge kk for slots of 'slot' cycles.
  function automatic logic [7:0] exp_an(input int kk, input int slot);
    logic [7:0] one;
    int d;
    one = 8'h01;
    d = ((kk - 1) / slot) % 8;
    return ~(one << d);
  endfunction

  // Scroll position after edge j in the scroll / shrink phase.
  function automatic int p_at(input int j);
    if (j <= 70) return (j / 10) % 4;
    if (j < 80)  return 0;
    if (j < 90)  return 1;
    return 0;
  endfunction

  initial begin
    int d, p, len, nxt;
    logic [7:0] ec;
    msg[0] = 8'h87; msg[1] = 8'hAF; msg[2] = 8'h88; msg[3] = 8'h87;

    // ---- reset hold and scan sequence ----
    do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_anodo", anodo, 8'hFF);
    check_eq("rst_catodo", catodo, 8'hFF);
    check_eq("rst_wrap", scroll_wrap, 1'b0);
`ifdef SEG_DEADTIME_EN
    check_eq("rst_anodo3", anodo3, 8'hFF);
`endif
    reset = 1'b1;
    k = 0;
    while (k < 40) begin
      step();
      check_eq("scan_anodo", anodo, exp_an(k, 4));
      check_eq("scan_catodo", catodo, 8'hFF);
`ifdef SEG_DEADTIME_EN
      ec = (((k - 1) % 16) < 2) ? 8'hFF : exp_an(k, 16);
      check_eq("dead_anodo3", anodo3, ec);
      check_eq("dead_catodo3", catodo3, 8'hFF);
`endif
    end

    // ---- static display ----
    do_reset();
    msg_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
      step();
    end
    wr_en = 1'b0;
    while (k < 40) begin
      step();
      d = ((k - 1) / 4) % 8;
      check_eq("static_anodo", anodo, exp_an(k, 4));
      check_eq("static_catodo", catodo, (d < 4) ? msg[d] : 8'hFF);
    end
    // Asynchronous reset mid-slot clears the outputs at once.
    #2 reset = 1'b0;
    #1;
    check_eq("async_anodo", anodo, 8'hFF);
    check_eq("async_catodo", catodo, 8'hFF);
`ifdef SEG_DEADTIME_EN
    check_eq("async_anodo3", anodo3, 8'hFF);
`endif

    // ---- circular scroll, length shrink, zero length ----
    do_reset();
    msg_len = 5'd4;
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
      step();
    end
    wr_en = 1'b0;
    while (k < 100) begin
      nxt = k + 1;
      msg_len = (nxt <= 70) ? 5'd4 : (nxt <= 90) ? 5'd2 : 5'd0;
      step();
      len = (k <= 70) ? 4 : (k <= 90) ? 2 : 0;
      d = ((k - 1) / 4) % 8;
      p = p_at(k - 1);
      ec = (len == 0) ? 8'hFF : msg[(p + d) % len];
      check_eq("scroll_catodo", catodo, ec);
      check_eq("scroll_wrap", scroll_wrap, (k == 40 || k == 90) ? 1'b1 : 1'b0);
    end

    // ---- write collision (main) and out-of-range write (12-entry) ----
    do_reset();
    msg_len = 5'd4;
    msg_len2 = 4'd12;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
      wr_en2 = (i < 2);
      wr_addr2 = (i == 0) ? 4'd13 : 4'd5;
      wr_data2 = (i == 0) ? 8'h00 : 8'h92;
      step();
    end
    wr_en = 1'b0;
    wr_en2 = 1'b0;
    while (k < 40) begin
      if (k == 33) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hC6;
      end else begin
        wr_en = 1'b0;
      end
      step();
      d = ((k - 1) / 4) % 8;
      check_eq("range_catodo2", catodo2, (d == 5) ? 8'h92 : 8'hFF);
      if (k >= 33 && k <= 36)
        check_eq("collide_catodo", catodo, (k <= 34) ? 8'h87 : 8'hC6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
